sha256d_header_sequencer: RTL and testbench
===========================================

// Module: sha256d_header_sequencer
// PURPOSE
//  - Drives one sha256_core to compute SHA-256d (double SHA-256) of an 80-byte Bitcoin block header.
//  - Sits directly upstream of sha256_core and issues three compression passes:
//    block1, block2 chained via midstate IV, then the second hash.
//  - Captures the final digest for the downstream target comparator.
// PARAMETERS
//  - WDOG_CYCLES  1024  max cycles allowed in any core wait state before error; 0 = watchdog off
// PORTS
//  - clk          in   1    system clock
//  - rst          in   1    synchronous reset, active-high
//  - start        in   1    1-cycle request; accepted only in IDLE
//  - header       in   608  header bytes 0..75; byte 0 = header[607:600]
//  - nonce        in   32   header bytes 76..79, byte 76 = nonce[31:24]; no byte swap applied
//  - reuse_mid    in   1    skip block1 and use the cached midstate (MIDSTATE_CACHE_EN only)
//  - core_start   out  1    1-cycle start pulse to sha256_core
//  - core_block   out  512  block to sha256_core
//  - core_use_iv  out  1    1 = core uses core_iv; 0 = standard SHA-256 IV
//  - core_iv      out  256  chaining value (midstate)
//  - core_done    in   1    sha256_core done
//  - core_hash    in   256  sha256_core result
//  - busy         out  1    high from the cycle after start is accepted until done
//  - done         out  1    1-cycle pulse; digest is valid in the same cycle
//  - digest       out  256  SHA-256d result, big-endian (raw, not byte-reversed)
//  - error        out  1    sticky watchdog flag; cleared by the next accepted start
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, digest=0, midstate register=0, mid_valid=0.
//  - Message and blocks:
//    - M = {header, nonce}, 640 bits.
//    - B1 = M[639:128].
//    - B2 = {M[127:0], 8'h80, 312'd0, 64'd640}.
//    - B3 = {H2, 8'h80, 184'd0, 64'd256}.
//  - Core controls per pass: B1 use_iv=0; B2 use_iv=1, iv=H1; B3 use_iv=0.
//  - header and nonce are registered at accept; input changes during busy have no effect.
//  - FSM sequence: IDLE -> S1 -> W1 -> S2 -> W2 -> S3 -> W3 -> FIN -> IDLE.
//    - Sn states last 1 cycle: core_start=1, with core_block/core_use_iv/core_iv valid.
//    - core_block/core_use_iv/core_iv stay stable through the matching Wn state.
//    - Wn: core_done is ignored in the cycle immediately after core_start (stale-done guard).
//    - Wn: the first later cycle with core_done=1 captures core_hash (H1, H2, H3) and advances.
//    - FIN: done=1 and digest=H3 for 1 cycle; busy drops in the same cycle.
//  - Latency: with core latency Lc (core_start to core_done), done comes 3*(Lc+1)+2 cycles after start.
//  - Output holding: digest holds until the next done or reset; done never asserts twice per start.
//  - start while busy: ignored (no queueing). start and rst in the same cycle: rst wins.
//  - rst mid-operation: core_start drops the next edge and the FSM goes to IDLE.
//    A core_done arriving later is ignored in IDLE.
//  - Watchdog (WDOG_CYCLES != 0):
//    - A counter runs in each Wn state and clears on each Sn state.
//    - Reaching WDOG_CYCLES sets error=1 and returns to IDLE with no done pulse.
//    - digest is unchanged.
// CONFIGURATION
//  - MIDSTATE_CACHE_EN defined:
//    - H1 is stored as midstate, and mid_valid=1 after each W1 capture.
//    - start with reuse_mid=1 and mid_valid=1 goes IDLE -> S2 (2 core passes).
//    - Latency becomes 2*(Lc+1)+2.
//    - The caller guarantees that header bytes 0..63 are unchanged.
//  - MIDSTATE_CACHE_EN undefined: reuse_mid is ignored; every start runs all three passes.
// TESTING
//  - T1 genesis header, nonce=32'h1dac2b7c, header =
//    0100..00 3ba3edfd..4b1e5e4a 29ab5f49 ffff001d (76 bytes)
//    -> done pulse, digest=256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000.
//  - T2 header=0, nonce=0: check core_block and core_use_iv at each core_start.
//    -> B2 tail = 8'h80,312'd0,64'h280; B3 tail = 8'h80,184'd0,64'h100; exactly 3 core_start pulses.
//  - T3 start re-pulsed in W1 and W2 -> ignored; exactly 1 done; digest equal to the T1 run.
//  - T4 rst asserted in W2 -> next cycle busy=0, core_start=0; a subsequent start gives the correct digest.
//  - T5 WDOG_CYCLES=16, bench model holds core_done=0 after S1
//    -> error=1 16 cycles into W1; no done; next start clears error.
//  - T6 MIDSTATE_CACHE_EN: T1 run, then same header with nonce=32'h1dac2b7d and reuse_mid=1
//    -> 2 core_start pulses; digest matches a full 3-pass run with reuse_mid=0.

Source files
------------

// File: rtl/sha256d_header_sequencer.sv
// sha256d_header_sequencer
//
// Computes SHA-256d (double SHA-256) of an 80-byte Bitcoin block header by
// driving a single sha256_core through three compression passes:
//   pass 1: B1 = first 64 message bytes, standard IV      -> H1 (midstate)
//   pass 2: B2 = last 16 message bytes + padding, IV = H1 -> H2
//   pass 3: B3 = H2 + padding, standard IV                -> H3 (digest)
// The message is {header, nonce}, taken as raw big-endian bytes. The nonce
// is not byte-swapped.
//
// Optional build macro MIDSTATE_CACHE_EN keeps H1 between runs. A start with
// reuse_mid=1 then skips pass 1 when a midstate is cached. The caller must
// keep header bytes 0..63 unchanged for that run.
//
// Parameter
//   WDOG_CYCLES  maximum cycles spent waiting on the core per pass before the
//                run is abandoned with error=1 (0 disables the watchdog)
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   start        1-cycle request, accepted only when idle
//   header       header bytes 0..75 (byte 0 = header[607:600])
//   nonce        header bytes 76..79 (byte 76 = nonce[31:24])
//   reuse_mid    skip pass 1 using the cached midstate (cache build only)
//   core_start   1-cycle start pulse to sha256_core
//   core_block   512-bit block for the current pass
//   core_use_iv  1 = core starts from core_iv, 0 = standard SHA-256 IV
//   core_iv      chaining value for pass 2 (H1)
//   core_done    core completion strobe
//   core_hash    core result
//   busy         run in progress (from the cycle after accept up to done)
//   done         1-cycle pulse, digest valid in the same cycle
//   digest       SHA-256d result, big-endian, not byte-reversed
//   error        sticky watchdog flag, cleared by the next accepted start
module sha256d_header_sequencer #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [607:0] header,
  input  logic [31:0]  nonce,
  input  logic         reuse_mid,
  output logic         core_start,
  output logic [511:0] core_block,
  output logic         core_use_iv,
  output logic [255:0] core_iv,
  input  logic         core_done,
  input  logic [255:0] core_hash,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest,
  output logic         error
);

  typedef enum logic [2:0] {IDLE, S1, W1, S2, W2, S3, W3, FIN} state_t;

  localparam int WDW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  state_t         state_reg, state_next;
  logic [607:0]   hdr_reg;
  logic [31:0]    nonce_reg;
  logic [255:0]   mid_reg;
  logic [255:0]   h2_reg;
  logic [255:0]   digest_reg;
  logic           error_reg;
  logic           armed_reg;
  logic [WDW-1:0] wdog_cnt_reg;

  logic           is_wait;
  logic           capture;
  logic           wdog_hit;
  logic           timeout;
  logic           accept;
  logic           use_mid;
  logic [511:0]   blk1, blk2, blk3;

`ifdef MIDSTATE_CACHE_EN
  logic mid_valid_reg;
  assign use_mid = reuse_mid & mid_valid_reg;
`else
  logic unused_reuse_mid;
  assign unused_reuse_mid = reuse_mid;
  assign use_mid          = 1'b0;
`endif

  assign blk1 = hdr_reg[607:96];
  assign blk2 = {hdr_reg[95:0], nonce_reg, 8'h80, 312'd0, 64'd640};
  assign blk3 = {h2_reg, 8'h80, 184'd0, 64'd256};

  assign is_wait = (state_reg == W1) || (state_reg == W2) || (state_reg == W3);
  // armed_reg is low in the first wait cycle, so a done strobe left over
  // from the previous pass cannot be taken as this pass's result.
  assign capture = is_wait && armed_reg && core_done;
  assign accept  = (state_reg == IDLE) && start;

  generate
    if (WDOG_CYCLES != 0) begin : g_wdog
      assign wdog_hit = (wdog_cnt_reg == WDW'(WDOG_CYCLES - 1));
    end else begin : g_no_wdog
      assign wdog_hit = 1'b0;
    end
  endgenerate

  // A result arriving in the last allowed cycle still wins over the timeout.
  assign timeout = is_wait && !capture && wdog_hit;

  assign digest = digest_reg;
  assign error  = error_reg;

  always_comb begin
    state_next  = state_reg;
    core_start  = 1'b0;
    core_block  = '0;
    core_use_iv = 1'b0;
    core_iv     = '0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = use_mid ? S2 : S1;
      end
      S1: begin
        core_start = 1'b1;
        core_block = blk1;
        state_next = W1;
      end
      W1: begin
        core_block = blk1;
        if (capture)      state_next = S2;
        else if (timeout) state_next = IDLE;
      end
      S2: begin
        core_start  = 1'b1;
        core_block  = blk2;
        core_use_iv = 1'b1;
        core_iv     = mid_reg;
        state_next  = W2;
      end
      W2: begin
        core_block  = blk2;
        core_use_iv = 1'b1;
        core_iv     = mid_reg;
        if (capture)      state_next = S3;
        else if (timeout) state_next = IDLE;
      end
      S3: begin
        core_start = 1'b1;
        core_block = blk3;
        state_next = W3;
      end
      W3: begin
        core_block = blk3;
        if (capture)      state_next = FIN;
        else if (timeout) state_next = IDLE;
      end
      FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      hdr_reg      <= '0;
      nonce_reg    <= '0;
      mid_reg      <= '0;
      h2_reg       <= '0;
      digest_reg   <= '0;
      error_reg    <= 1'b0;
      armed_reg    <= 1'b0;
      wdog_cnt_reg <= '0;
`ifdef MIDSTATE_CACHE_EN
      mid_valid_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      armed_reg    <= is_wait;
      wdog_cnt_reg <= is_wait ? wdog_cnt_reg + 1'b1 : '0;
      if (accept) begin
        hdr_reg   <= header;
        nonce_reg <= nonce;
        error_reg <= 1'b0;
      end
      if (timeout) error_reg <= 1'b1;
      if (capture) begin
        case (state_reg)
          W1: begin
            mid_reg <= core_hash;
`ifdef MIDSTATE_CACHE_EN
            mid_valid_reg <= 1'b1;
`endif
          end
          W2:      h2_reg     <= core_hash;
          W3:      digest_reg <= core_hash;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256d_header_sequencer.sv
// Directed bench for sha256d_header_sequencer. A behavioural sha256_core
// answers each core_start after LC cycles. An optional early stray done and
// an optional held-off done exercise the guard and the watchdog. Latencies
// are counted inclusively, with the start cycle as cycle 1.
module tb_sha256d_header_sequencer;

  localparam int LC   = 4;
  localparam int WDOG = 16;
  localparam int FULL_LAT  = 3 * (LC + 1) + 2;
  localparam int REUSE_LAT = 2 * (LC + 1) + 2;
`ifdef MIDSTATE_CACHE_EN
  localparam int EXP_REUSE_STARTS = 2;
  localparam int EXP_REUSE_LAT    = REUSE_LAT;
`else
  localparam int EXP_REUSE_STARTS = 3;
  localparam int EXP_REUSE_LAT    = FULL_LAT;
`endif

  localparam logic [255:0] SHA_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [607:0] GEN_HDR = {32'h01000000, 256'd0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d};
  localparam logic [255:0] GEN_DIGEST =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst, start, reuse_mid;
  logic [607:0] header;
  logic [31:0]  nonce;
  logic         core_start, core_use_iv, core_done;
  logic [511:0] core_block;
  logic [255:0] core_iv, core_hash, digest;
  logic         busy, done, error;

  logic         core_rst, hold_done, stale_en;
  int           cm_cnt;
  logic [255:0] cm_res;

  int n_chk = 0;
  int n_err = 0;
  int n_cs  = 0;
  int n_dn  = 0;
  logic [511:0] log_blk [16];
  logic         log_uiv [16];
  logic [255:0] log_iv  [16];

  always #5 clk = ~clk;

  sha256d_header_sequencer #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .header(header), .nonce(nonce),
    .reuse_mid(reuse_mid), .core_start(core_start), .core_block(core_block),
    .core_use_iv(core_use_iv), .core_iv(core_iv), .core_done(core_done),
    .core_hash(core_hash), .busy(busy), .done(done), .digest(digest),
    .error(error));

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = hin[255:224]; b = hin[223:192]; c = hin[191:160]; d = hin[159:128];
    e = hin[127:96];  f = hin[95:64];   g = hin[63:32];   h = hin[31:0];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [255:0] sha256d_ref(input logic [607:0] hdr, input logic [31:0] nce);
    logic [639:0] m;
    logic [255:0] h1, h2;
    m  = {hdr, nce};
    h1 = sha_compress(SHA_IV, m[639:128]);
    h2 = sha_compress(h1, {m[127:0], 8'h80, 312'd0, 64'd640});
    return sha_compress(SHA_IV, {h2, 8'h80, 184'd0, 64'd256});
  endfunction

  // Behavioural core: result LC cycles after core_start, optional stray
  // done in the first wait cycle, optional suppression of the real done.
  always @(posedge clk) begin
    if (core_rst) begin
      core_done <= 1'b0;
      core_hash <= '0;
      cm_cnt    <= 0;
      cm_res    <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        cm_res <= sha_compress(core_use_iv ? core_iv : SHA_IV, core_block);
        cm_cnt <= LC - 1;
        if (stale_en) begin
          core_done <= 1'b1;
          core_hash <= {8{32'hdeadbeef}};
        end
      end else if (cm_cnt > 0) begin
        cm_cnt <= cm_cnt - 1;
        if (cm_cnt == 1 && !hold_done) begin
          core_done <= 1'b1;
          core_hash <= cm_res;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (core_start) begin
      log_blk[n_cs % 16] <= core_block;
      log_uiv[n_cs % 16] <= core_use_iv;
      log_iv[n_cs % 16]  <= core_iv;
      n_cs <= n_cs + 1;
    end
    if (done) n_dn <= n_dn + 1;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Returns in the done cycle (or after an abort).
  task automatic run(input string tag, input logic [607:0] hdr, input logic [31:0] nce,
                     input logic reuse, input bit repulse, input int abort_cyc,
                     output int cycles, output bit got_done);
    bit aborted;
    got_done = 0;
    cycles   = 0;
    aborted  = 0;
    header = hdr; nonce = nce; reuse_mid = reuse; start = 1'b1;
    for (int c = 2; c <= 200; c++) begin
      @(negedge clk);
      start  = repulse && (c == 4 || c == 9);
      header = start ? ~hdr : hdr;
      nonce  = start ? ~nce : nce;
      if (c == abort_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_busy_after_rst"}, 512'(busy), 512'(1'b0));
        check({tag, "_core_start_after_rst"}, 512'(core_start), 512'(1'b0));
        cycles  = c;
        aborted = 1;
        break;
      end
      if (done) begin
        got_done = 1;
        cycles   = c;
        break;
      end
    end
    start = 1'b0;
    $display("run %s: done=%0d aborted=%0d cycles=%0d digest=%h", tag, got_done, aborted, cycles, digest);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, cs0, dn0, err_cyc;
    bit ok;
    logic [511:0] b2z, b3z;
    logic [255:0] h1z, h2z, d7d;

    rst = 1'b1; core_rst = 1'b1; start = 1'b0; header = '0; nonce = '0;
    reuse_mid = 1'b0; hold_done = 1'b0; stale_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 512'(busy), 512'(1'b0));
    check("rst_done", 512'(done), 512'(1'b0));
    check("rst_error", 512'(error), 512'(1'b0));
    check("rst_digest", 512'(digest), 512'd0);
    check("rst_core_start", 512'(core_start), 512'(1'b0));
    check("rst_core_block", core_block, 512'd0);
    check("rst_core_use_iv", 512'(core_use_iv), 512'(1'b0));
    check("rst_core_iv", 512'(core_iv), 512'd0);
    rst = 1'b0; core_rst = 1'b0;
    @(negedge clk);

    // T1: genesis header
    cs0 = n_cs; dn0 = n_dn;
    run("t1_genesis", GEN_HDR, 32'h1dac2b7c, 1'b0, 0, 0, cyc, ok);
    check("t1_done", 512'(ok), 512'(1'b1));
    check("t1_digest", 512'(digest), 512'(GEN_DIGEST));
    check("t1_latency", 512'(cyc), 512'(FULL_LAT));
    check("t1_busy_in_done", 512'(busy), 512'(1'b0));
    @(negedge clk);
    check("t1_done_one_cycle", 512'(done), 512'(1'b0));
    repeat (3) @(negedge clk);
    check("t1_done_pulses", 512'(n_dn - dn0), 512'(1));
    check("t1_core_starts", 512'(n_cs - cs0), 512'(3));
    check("t1_digest_hold", 512'(digest), 512'(GEN_DIGEST));

    // T2: all-zero message, blocks at each core_start, stray early done
    b2z = {128'd0, 8'h80, 312'd0, 64'h280};
    h1z = sha_compress(SHA_IV, 512'd0);
    h2z = sha_compress(h1z, b2z);
    b3z = {h2z, 8'h80, 184'd0, 64'h100};
    stale_en = 1'b1;
    cs0 = n_cs;
    run("t2_zero", '0, 32'd0, 1'b0, 0, 0, cyc, ok);
    check("t2_done", 512'(ok), 512'(1'b1));
    check("t2_digest", 512'(digest), 512'(sha_compress(SHA_IV, b3z)));
    repeat (3) @(negedge clk);
    stale_en = 1'b0;
    check("t2_core_starts", 512'(n_cs - cs0), 512'(3));
    check("t2_b1", log_blk[cs0 % 16], 512'd0);
    check("t2_b1_use_iv", 512'(log_uiv[cs0 % 16]), 512'(1'b0));
    check("t2_b2", log_blk[(cs0 + 1) % 16], b2z);
    check("t2_b2_use_iv", 512'(log_uiv[(cs0 + 1) % 16]), 512'(1'b1));
    check("t2_b2_iv", 512'(log_iv[(cs0 + 1) % 16]), 512'(h1z));
    check("t2_b3", log_blk[(cs0 + 2) % 16], b3z);
    check("t2_b3_use_iv", 512'(log_uiv[(cs0 + 2) % 16]), 512'(1'b0));

    // T3: start re-pulsed (with other data) in W1 and W2
    cs0 = n_cs; dn0 = n_dn;
    run("t3_repulse", GEN_HDR, 32'h1dac2b7c, 1'b0, 1, 0, cyc, ok);
    check("t3_done", 512'(ok), 512'(1'b1));
    check("t3_digest", 512'(digest), 512'(GEN_DIGEST));
    check("t3_latency", 512'(cyc), 512'(FULL_LAT));
    repeat (20) @(negedge clk);
    check("t3_done_pulses", 512'(n_dn - dn0), 512'(1));
    check("t3_core_starts", 512'(n_cs - cs0), 512'(3));

    // T4: reset in W2; the late core_done lands in IDLE
    dn0 = n_dn;
    run("t4_abort", GEN_HDR, 32'h1dac2b7c, 1'b0, 0, 9, cyc, ok);
    repeat (6) @(negedge clk);
    check("t4_busy_idle", 512'(busy), 512'(1'b0));
    check("t4_no_done", 512'(n_dn - dn0), 512'(0));
    d7d = sha256d_ref(GEN_HDR, 32'h1dac2b7d);
    run("t4_restart", GEN_HDR, 32'h1dac2b7d, 1'b0, 0, 0, cyc, ok);
    check("t4_done", 512'(ok), 512'(1'b1));
    check("t4_digest", 512'(digest), 512'(d7d));
    repeat (2) @(negedge clk);

    // T5: core never answers pass 1
    dn0 = n_dn; err_cyc = 0;
    hold_done = 1'b1;
    header = GEN_HDR; nonce = 32'h0; reuse_mid = 1'b0; start = 1'b1;
    for (int c = 2; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 18) check("t5_error_early", 512'(error), 512'(1'b0));
      if (error) begin
        err_cyc = c;
        break;
      end
    end
    $display("run t5_wdog: error_cycle=%0d", err_cyc);
    check("t5_error_cycle", 512'(err_cyc), 512'(19));
    check("t5_busy", 512'(busy), 512'(1'b0));
    repeat (5) @(negedge clk);
    hold_done = 1'b0;
    check("t5_error_sticky", 512'(error), 512'(1'b1));
    check("t5_no_done", 512'(n_dn - dn0), 512'(0));
    check("t5_digest_kept", 512'(digest), 512'(d7d));
    run("t5_recover", GEN_HDR, 32'h1dac2b7c, 1'b0, 0, 0, cyc, ok);
    check("t5_error_cleared", 512'(error), 512'(1'b0));
    check("t5_digest", 512'(digest), 512'(GEN_DIGEST));
    repeat (2) @(negedge clk);

    // T6: same first 64 bytes, next nonce, reuse_mid=1
    cs0 = n_cs;
    run("t6_reuse", GEN_HDR, 32'h1dac2b7d, 1'b1, 0, 0, cyc, ok);
    check("t6_done", 512'(ok), 512'(1'b1));
    check("t6_digest", 512'(digest), 512'(d7d));
    check("t6_latency", 512'(cyc), 512'(EXP_REUSE_LAT));
    repeat (3) @(negedge clk);
    check("t6_core_starts", 512'(n_cs - cs0), 512'(EXP_REUSE_STARTS));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
